// File: rtl/nios2_oci_trace_capture_pkg.sv
// Shared OCI trace definitions: FSM state encodings, drop-counter width
// and the saturating increment used by the lost-frame counter.
package nios2_oci_trace_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_FLUSH   = 2'd2,
        ST_ENDED   = 2'd3
    } oci_state_e;

    localparam int DROP_W = 8;
    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    function automatic logic [DROP_W-1:0] sat_inc(
        input logic [DROP_W-1:0] v
    );
        return (v == DROP_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/nios2_oci_trace_capture_if.sv
// Trace capture bus: frame input side and debug readout side.
// master = trace source / reader, slave = capture block.
//   dct_buffer/dct_count/dct_valid : frame payload, slot count, strobe
//   rd_req                         : pop request
//   rd_data/rd_valid/level         : head entry, non-empty, entry count
interface nios2_oci_trace_capture_if #(
    parameter int FRAME_W = 30,
    parameter int CNT_W   = 4,
    parameter int DEPTH   = 16
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic [FRAME_W-1:0]       dct_buffer;
    logic [CNT_W-1:0]         dct_count;
    logic                     dct_valid;
    logic                     rd_req;
    logic [FRAME_W+CNT_W-1:0] rd_data;
    logic                     rd_valid;
    logic [LVL_W-1:0]         level;

    modport master (
        output dct_buffer, dct_count, dct_valid, rd_req,
        input  rd_data, rd_valid, level
    );

    modport slave (
        input  dct_buffer, dct_count, dct_valid, rd_req,
        output rd_data, rd_valid, level
    );

endinterface

// File: rtl/nios2_oci_trace_capture_fifo.sv
// First-word fall-through trace FIFO with optional overwrite-oldest mode.
// Ports: wr_en/wr_data push, rd_en pop, wrap_en selects overwrite on full,
// rd_data/rd_valid head entry (zero when empty), level entry count,
// lost pulses when a push hits a full FIFO without a concurrent pop.
module nios2_oci_trace_fifo #(
    parameter  int WIDTH = 34,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic             wrap_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic [AW:0]      level,
    output logic             lost
);

    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      cnt;

    logic empty;
    logic full;
    logic pop;
    logic push;
    logic evict;

    assign empty = (cnt == '0);
    assign full  = (cnt == FULL_LVL);
    assign pop   = rd_en && !empty;

    // A full FIFO still accepts a push when the same cycle pops,
    // or when overwrite mode lets the oldest entry be evicted.
    assign push  = wr_en && (!full || pop || wrap_en);
    assign evict = push && full && !pop;
    assign lost  = wr_en && full && !pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop || evict) begin
                rptr <= rptr + 1'b1;
            end
            if (push && !(pop || evict)) begin
                cnt <= cnt + 1'b1;
            end else if (!push && pop) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= wr_data;
        end
    end

    assign rd_data  = empty ? '0 : mem[rptr];
    assign rd_valid = !empty;
    assign level    = cnt;

endmodule

// File: rtl/nios2_oci_trace_capture.sv
// Nios II OCI trace capture: buffers qualifying trace frames, tracks
// losses and sequences capture -> flush -> ended.
// Ports: clk, reset (async, active-high), bus (frame in / readout out),
// test_ending (stop and drain), test_has_ended (freeze now),
// overflow (sticky loss), drop_cnt (saturating loss count),
// state (FSM encoding), flushed (drain complete, sticky).
module nios2_oci_trace_capture
    import nios2_oci_trace_capture_pkg::*;
#(
    parameter int FRAME_W = 30,
    parameter int CNT_W   = 4,
    parameter int DEPTH   = 16,
    parameter int WRAP    = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    nios2_oci_trace_capture_if.slave   bus,
    input  logic                       test_ending,
    input  logic                       test_has_ended,
    output logic                       overflow,
    output logic [DROP_W-1:0]          drop_cnt,
    output logic [1:0]                 state,
    output logic                       flushed
);

    localparam int WIDTH = FRAME_W + CNT_W;

    oci_state_e st;

    logic             qual;
    logic             wr_open;
    logic             wr_en;
    logic             lost;
    logic             wrap_en;
    logic             lvl_zero;
    logic [WIDTH-1:0] wr_data;

    // Empty frames carry no trace slots; they are neither stored nor lost.
    assign qual     = bus.dct_valid && (bus.dct_count != '0);
    assign wr_open  = ((st == ST_IDLE) || (st == ST_CAPTURE))
                      && !test_has_ended;
    assign wr_en    = qual && wr_open;
    assign wr_data  = {bus.dct_count, bus.dct_buffer};
    assign wrap_en  = (WRAP != 0);
    assign lvl_zero = (bus.level == '0);

    nios2_oci_trace_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (bus.rd_req),
        .wrap_en  (wrap_en),
        .rd_data  (bus.rd_data),
        .rd_valid (bus.rd_valid),
        .level    (bus.level),
        .lost     (lost)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st       <= ST_IDLE;
            overflow <= 1'b0;
            drop_cnt <= '0;
            flushed  <= 1'b0;
        end else begin
            if (lost) begin
                overflow <= 1'b1;
                drop_cnt <= sat_inc(drop_cnt);
            end
            if (test_has_ended) begin
                // Freeze wins over drain; only an already-empty FIFO
                // counts as a completed flush.
                st <= ST_ENDED;
                if ((test_ending || st == ST_FLUSH) && lvl_zero
                    && st != ST_ENDED) begin
                    flushed <= 1'b1;
                end
            end else begin
                unique case (st)
                    ST_IDLE: begin
                        if (test_ending) begin
                            st <= ST_FLUSH;
                        end else if (qual) begin
                            st <= ST_CAPTURE;
                        end
                    end
                    ST_CAPTURE: begin
                        if (test_ending) begin
                            st <= ST_FLUSH;
                        end
                    end
                    ST_FLUSH: begin
                        if (lvl_zero) begin
                            st      <= ST_ENDED;
                            flushed <= 1'b1;
                        end
                    end
                    ST_ENDED: begin
                        st <= ST_ENDED;
                    end
                endcase
            end
        end
    end

    assign state = st;

endmodule

// File: tb/tb_nios2_oci_trace_capture.sv
// Directed self-checking bench for nios2_oci_trace_capture.
// Two DUTs (WRAP=0 and WRAP=1, DEPTH=4) share one stimulus stream.
module tb_nios2_oci_trace_capture;

    localparam int FW = 30;
    localparam int CW = 4;
    localparam int DP = 4;

    logic clk;
    logic reset;
    logic [FW-1:0] dct_buffer;
    logic [CW-1:0] dct_count;
    logic dct_valid;
    logic rd_req;
    logic test_ending;
    logic test_has_ended;

    logic       ovf0, ovf1;
    logic [7:0] drop0, drop1;
    logic [1:0] st0, st1;
    logic       fl0, fl1;

    int checks;
    int failures;

    nios2_oci_trace_capture_if #(.FRAME_W(FW), .CNT_W(CW), .DEPTH(DP)) if0 ();
    nios2_oci_trace_capture_if #(.FRAME_W(FW), .CNT_W(CW), .DEPTH(DP)) if1 ();

    assign if0.dct_buffer = dct_buffer;
    assign if0.dct_count  = dct_count;
    assign if0.dct_valid  = dct_valid;
    assign if0.rd_req     = rd_req;
    assign if1.dct_buffer = dct_buffer;
    assign if1.dct_count  = dct_count;
    assign if1.dct_valid  = dct_valid;
    assign if1.rd_req     = rd_req;

    nios2_oci_trace_capture #(
        .FRAME_W(FW), .CNT_W(CW), .DEPTH(DP), .WRAP(0)
    ) dut0 (
        .clk(clk), .reset(reset), .bus(if0.slave),
        .test_ending(test_ending), .test_has_ended(test_has_ended),
        .overflow(ovf0), .drop_cnt(drop0), .state(st0), .flushed(fl0)
    );

    nios2_oci_trace_capture #(
        .FRAME_W(FW), .CNT_W(CW), .DEPTH(DP), .WRAP(1)
    ) dut1 (
        .clk(clk), .reset(reset), .bus(if1.slave),
        .test_ending(test_ending), .test_has_ended(test_has_ended),
        .overflow(ovf1), .drop_cnt(drop1), .state(st1), .flushed(fl1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [FW+CW-1:0] ent(input int b, input int c);
        return {CW'(c), FW'(b)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input int b, input int c);
        dct_valid  = 1'b1;
        dct_buffer = FW'(b);
        dct_count  = CW'(c);
        tick();
        dct_valid  = 1'b0;
    endtask

    task automatic pop();
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        reset          = 1'b1;
        dct_buffer     = '0;
        dct_count      = '0;
        dct_valid      = 1'b0;
        rd_req         = 1'b0;
        test_ending    = 1'b0;
        test_has_ended = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        chk("rst_state", 64'(st0), 64'd0);
        chk("rst_level", 64'(if0.level), 64'd0);
        chk("rst_rdv", 64'(if0.rd_valid), 64'd0);
        chk("rst_rdata", 64'(if0.rd_data), 64'd0);
        chk("rst_ovf", 64'(ovf0), 64'd0);
        chk("rst_drop", 64'(drop0), 64'd0);
        chk("rst_flushed", 64'(fl0), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Fill 6 frames into a 4-deep FIFO with no pops
        frame(1, 1);
        chk("fwft_rdv", 64'(if0.rd_valid), 64'd1);
        chk("fwft_rdata", 64'(if0.rd_data), 64'(ent(1, 1)));
        chk("capture_state", 64'(st0), 64'd1);
        for (int i = 2; i <= 6; i++) frame(i, 1);
        chk("nowrap_level", 64'(if0.level), 64'd4);
        chk("nowrap_drop", 64'(drop0), 64'd2);
        chk("nowrap_ovf", 64'(ovf0), 64'd1);
        chk("wrap_level", 64'(if1.level), 64'd4);
        chk("wrap_drop", 64'(drop1), 64'd2);
        chk("wrap_ovf", 64'(ovf1), 64'd1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("nowrap_pop%0d", i), 64'(if0.rd_data),
                64'(ent(1 + i, 1)));
            chk($sformatf("wrap_pop%0d", i), 64'(if1.rd_data),
                64'(ent(3 + i, 1)));
            pop();
        end
        chk("empty_level", 64'(if0.level), 64'd0);
        chk("empty_rdata", 64'(if0.rd_data), 64'd0);
        pop();
        chk("pop_empty_level", 64'(if0.level), 64'd0);
        frame(9, 0);
        chk("zero_cnt_level", 64'(if0.level), 64'd0);
        chk("zero_cnt_drop", 64'(drop0), 64'd2);

        // Full FIFO with simultaneous write and pop
        pulse_reset();
        for (int i = 10; i <= 13; i++) frame(i, 2);
        rd_req = 1'b1;
        frame(14, 2);
        rd_req = 1'b0;
        chk("wrpop_level", 64'(if0.level), 64'd4);
        chk("wrpop_drop", 64'(drop0), 64'd0);
        chk("wrpop_level_w", 64'(if1.level), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("wrpop_pop%0d", i), 64'(if0.rd_data),
                64'(ent(11 + i, 2)));
            pop();
        end
        chk("wrpop_empty", 64'(if0.rd_valid), 64'd0);

        // test_ending with a frame in the same cycle, then drain
        pulse_reset();
        for (int i = 20; i <= 22; i++) frame(i, 3);
        test_ending = 1'b1;
        frame(23, 3);
        test_ending = 1'b0;
        chk("flush_state", 64'(st0), 64'd2);
        chk("flush_level", 64'(if0.level), 64'd4);
        frame(24, 3);
        chk("flush_no_write", 64'(if0.level), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("flush_pop%0d", i), 64'(if0.rd_data),
                64'(ent(20 + i, 3)));
            pop();
        end
        chk("flush_still", 64'(st0), 64'd2);
        chk("flush_fl0", 64'(fl0), 64'd0);
        tick();
        chk("flush_ended", 64'(st0), 64'd3);
        chk("flush_fl1", 64'(fl0), 64'd1);
        tick();
        chk("flush_sticky", 64'(fl0), 64'd1);

        // test_has_ended beats test_ending
        pulse_reset();
        frame(30, 1);
        frame(31, 1);
        test_ending    = 1'b1;
        test_has_ended = 1'b1;
        frame(32, 1);
        test_ending    = 1'b0;
        test_has_ended = 1'b0;
        chk("hard_state", 64'(st0), 64'd3);
        chk("hard_flushed", 64'(fl0), 64'd0);
        chk("hard_level", 64'(if0.level), 64'd2);
        frame(33, 1);
        chk("hard_no_write", 64'(if0.level), 64'd2);
        chk("hard_pop0", 64'(if0.rd_data), 64'(ent(30, 1)));
        pop();
        chk("hard_pop1", 64'(if0.rd_data), 64'(ent(31, 1)));
        pop();
        chk("hard_empty", 64'(if0.level), 64'd0);
        chk("hard_stay", 64'(st0), 64'd3);

        // drop_cnt saturation
        pulse_reset();
        for (int i = 0; i < 264; i++) frame(i + 1, 1);
        chk("sat_drop0", 64'(drop0), 64'd255);
        chk("sat_drop1", 64'(drop1), 64'd255);

        // Asynchronous reset mid-stream
        pulse_reset();
        for (int i = 40; i <= 42; i++) frame(i, 1);
        chk("mid_level", 64'(if0.level), 64'd3);
        reset = 1'b1;
        #2;
        chk("async_state", 64'(st0), 64'd0);
        chk("async_level", 64'(if0.level), 64'd0);
        chk("async_rdv", 64'(if0.rd_valid), 64'd0);
        chk("async_rdata", 64'(if0.rd_data), 64'd0);
        chk("async_drop", 64'(drop0), 64'd0);
        chk("async_level_w", 64'(if1.level), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        chk("post_rst_level", 64'(if0.level), 64'd0);
        frame(50, 1);
        chk("post_rst_rdata", 64'(if0.rd_data), 64'(ent(50, 1)));
        chk("post_rst_lvl1", 64'(if0.level), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nios2_oci_trace_capture.md
NIOS2_OCI_TRACE_CAPTURE -- requirements
Module: nios2_oci_trace_capture

Interface
REQ-001 Parameter FRAME_W, default 30: width of one trace frame on dct_buffer.
REQ-002 Parameter CNT_W, default 4: width of dct_count.
REQ-003 Parameter DEPTH, default 16: FIFO entries; power of two, minimum 2.
REQ-004 Parameter WRAP, default 0: 0 drops new frames when full, 1 overwrites the oldest entry.
REQ-005 clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 dct_buffer  in  FRAME_W  trace frame payload.
REQ-008 dct_count  in  CNT_W  number of valid slots in the frame; 0 means empty frame.
REQ-009 dct_valid  in  1  frame strobe, one cycle per frame.
REQ-010 test_ending  in  1  request to stop capture and drain.
REQ-011 test_has_ended  in  1  immediate freeze of capture.
REQ-012 rd_req  in  1  pop request from the debug readout side.
REQ-013 rd_data  out  FRAME_W+CNT_W  head entry, {dct_count, dct_buffer}.
REQ-014 rd_valid  out  1  FIFO non-empty; rd_data is valid.
REQ-015 level  out  clog2(DEPTH)+1  current entry count, 0..DEPTH.
REQ-016 overflow  out  1  sticky flag: at least one frame dropped or overwritten.
REQ-017 drop_cnt  out  8  saturating count of lost frames.
REQ-018 state  out  2  current FSM state encoding.
REQ-019 flushed  out  1  drain completed after test_ending.

Function
REQ-020 The FSM SHALL have states IDLE=0, CAPTURE=1, FLUSH=2, ENDED=3.
REQ-021 A write-qualifying frame SHALL be dct_valid=1 with dct_count!=0; frames with dct_count=0 are ignored and not counted as lost.
REQ-022 IDLE SHALL go to CAPTURE on the first qualifying frame, and that frame SHALL be written.
REQ-023 Writes SHALL occur only in IDLE (the first frame) and CAPTURE.
REQ-024 A written entry SHALL appear on rd_data with rd_valid=1 on the next cycle when the FIFO was empty (first-word fall-through, 1-cycle latency).
REQ-025 A pop SHALL occur when rd_req=1 and rd_valid=1; rd_req with rd_valid=0 SHALL be ignored.
REQ-026 A simultaneous write and pop SHALL leave level unchanged, including when the FIFO is full.
REQ-027 Full with WRAP=0 and no pop: the write SHALL be discarded, overflow set, and drop_cnt incremented.
REQ-028 Full with WRAP=1 and no pop: the oldest entry SHALL be overwritten, the read pointer advanced, level held at DEPTH, overflow set, and drop_cnt incremented.
REQ-029 drop_cnt SHALL saturate at 255.
REQ-030 Pointers SHALL wrap modulo DEPTH.
REQ-031 test_ending=1 in IDLE or CAPTURE SHALL move the FSM to FLUSH; a qualifying frame in the same cycle SHALL still be written.
REQ-032 FLUSH SHALL accept pops only and SHALL go to ENDED with flushed=1 in the cycle after level reaches 0.
REQ-033 test_has_ended=1 in any state SHALL go to ENDED next cycle and block writes from that cycle; FIFO contents are retained.
REQ-034 test_has_ended SHALL take priority over test_ending in the same cycle, leaving flushed=0 unless level is already 0.
REQ-035 ENDED SHALL permit pops and SHALL be left only by reset.
REQ-036 flushed SHALL be sticky until reset.

Reset
REQ-037 Reset SHALL asynchronously force: state=IDLE, both pointers=0, level=0, rd_valid=0, overflow=0, drop_cnt=0, flushed=0.
REQ-038 rd_data SHALL read as all-zero while level=0.
REQ-039 Reset asserted mid-write or mid-flush SHALL discard all entries, with no partial pop or write visible after release.

Structure
REQ-040 State encodings and the drop-counter width SHALL live in the shared OCI package.
REQ-041 Storage and pointers SHALL be a sub-module nios2_oci_trace_fifo, parameterised by width and depth with a wrap-enable input; the FSM and counters SHALL live in the top level.

Verification
REQ-042 Bench: DEPTH=4, WRAP=0, 6 frames (count=1, buffer=1..6), no rd_req -> level=4, drop_cnt=2, overflow=1, pops return 1,2,3,4.
REQ-043 Bench: DEPTH=4, WRAP=1, same stimulus -> level=4, drop_cnt=2, pops return 3,4,5,6.
REQ-044 Bench: full FIFO with dct_valid and rd_req in the same cycle -> level stays 4, drop_cnt unchanged, new frame is last out.
REQ-045 Bench: 3 entries, pulse test_ending with a frame in the same cycle, then pop continuously -> 4 entries read, state FLUSH then ENDED, flushed=1.
REQ-046 Bench: test_has_ended and test_ending asserted together with 2 entries -> state=ENDED, flushed=0, later frames ignored, 2 entries still poppable.
REQ-047 Bench: reset pulsed mid-stream with 3 entries -> all outputs at reset values immediately, before the next clk edge.
